// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, control-bit indices and payload type for the MEM/WB stage
package pipe_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int REG_AW_DEF = 5;

   localparam int CTRL_REG_WRITE  = 1;
   localparam int CTRL_MEM_TO_REG = 0;

   typedef struct packed {
      logic [XLEN_DEF-1:0]   alu;
      logic [XLEN_DEF-1:0]   mem;
      logic [REG_AW_DEF-1:0] rd;
      logic [1:0]            ctrl;
   } mem_wb_payload_t;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one payload register plus valid bit with load/clear/flush
module pipe_slot #(
   parameter int W = 72
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush_i,
   input  logic         load_i,
   input  logic         clear_i,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q,  data_d;

   // Payload only moves on load; flush touches the valid bit alone.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (clear_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB stage register with flow control, flush and write-back select; MEM_WB_SKID_EN adds a skid slot
module mem_wb_stage
   import pipe_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_alu,
   input  logic [XLEN-1:0]   in_mem,
   input  logic [REG_AW-1:0] in_rd,
   input  logic [1:0]        in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              wb_we,
   output logic [REG_AW-1:0] wb_rd,
   output logic [XLEN-1:0]   wb_data
);

   typedef struct packed {
      logic [XLEN-1:0]   alu;
      logic [XLEN-1:0]   mem;
      logic [REG_AW-1:0] rd;
      logic [1:0]        ctrl;
   } payload_t;

   localparam int PW = $bits(payload_t);

   payload_t in_pl, main_pl, main_d;
   logic     main_v, main_load, main_clear;
   logic     accept, retire;

   assign in_pl  = '{alu: in_alu, mem: in_mem, rd: in_rd, ctrl: in_ctrl};
   assign accept = in_valid & in_ready & ~flush;
   assign retire = main_v & out_ready;

`ifdef MEM_WB_SKID_EN
   payload_t skid_pl;
   logic     skid_v, skid_load, skid_clear;

   // Ready depends only on registered skid state, never on out_ready.
   assign in_ready   = ~reset & (flush | ~skid_v);
   assign main_load  = (accept & (~main_v | out_ready)) | (skid_v & out_ready);
   assign main_d     = skid_v ? skid_pl : in_pl;
   assign main_clear = retire & ~main_load;
   assign skid_load  = accept & main_v & ~out_ready;
   assign skid_clear = skid_v & out_ready;

   pipe_slot #(.W(PW)) u_skid (
      .clk     (clk),
      .reset   (reset),
      .flush_i (flush),
      .load_i  (skid_load),
      .clear_i (skid_clear),
      .data_i  (in_pl),
      .valid_o (skid_v),
      .data_o  (skid_pl)
   );
`else
   assign in_ready   = ~reset & (flush | ~main_v | out_ready);
   assign main_load  = accept;
   assign main_d     = in_pl;
   assign main_clear = retire & ~main_load;
`endif

   pipe_slot #(.W(PW)) u_main (
      .clk     (clk),
      .reset   (reset),
      .flush_i (flush),
      .load_i  (main_load),
      .clear_i (main_clear),
      .data_i  (main_d),
      .valid_o (main_v),
      .data_o  (main_pl)
   );

   assign out_valid = main_v;
   assign wb_rd     = main_pl.rd;
   assign wb_data   = main_pl.ctrl[CTRL_MEM_TO_REG] ? main_pl.mem : main_pl.alu;
   assign wb_we     = main_v & main_pl.ctrl[CTRL_REG_WRITE] & (main_pl.rd != '0);

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage (single-slot build)
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready, out_valid, out_ready, wb_we;
   logic [31:0] in_alu, in_mem, wb_data;
   logic [4:0]  in_rd, wb_rd;
   logic [1:0]  in_ctrl;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_wb_stage dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_alu    (in_alu),
      .in_mem    (in_mem),
      .in_rd     (in_rd),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .wb_we     (wb_we),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [31:0] alu, input logic [31:0] mem,
                       input logic [4:0] rd, input logic [1:0] ctrl);
      in_valid = 1'b1;
      in_alu   = alu;
      in_mem   = mem;
      in_rd    = rd;
      in_ctrl  = ctrl;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_alu = '0; in_mem = '0; in_rd = '0; in_ctrl = '0;
      step();
      step();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_wb_we", wb_we, 0);
      chk("rst_wb_rd", wb_rd, 0);
      chk("rst_wb_data", wb_data, 0);

      reset = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);

      // streaming, out_ready=1, one beat per cycle
      out_ready = 1'b1;
      beat(32'h11, 32'h0, 5'd3, 2'b10);
      step();
      chk("s1_valid", out_valid, 1);
      chk("s1_we", wb_we, 1);
      chk("s1_rd", wb_rd, 3);
      chk("s1_data", wb_data, 32'h11);
      chk("s1_in_ready", in_ready, 1);
      beat(32'h12, 32'h0, 5'd3, 2'b10);
      step();
      chk("s2_valid", out_valid, 1);
      chk("s2_data", wb_data, 32'h12);
      beat(32'h13, 32'h0, 5'd4, 2'b10);
      step();
      chk("s3_data", wb_data, 32'h13);
      chk("s3_rd", wb_rd, 4);

      // mem_to_reg select, then x0 suppression
      beat(32'h5, 32'hDEADBEEF, 5'd3, 2'b11);
      step();
      chk("m2r_data", wb_data, 32'hDEADBEEF);
      chk("m2r_we", wb_we, 1);
      beat(32'h5, 32'hDEADBEEF, 5'd0, 2'b11);
      step();
      chk("x0_valid", out_valid, 1);
      chk("x0_we", wb_we, 0);
      chk("x0_rd", wb_rd, 0);
      in_valid = 1'b0;
      step();
      chk("idle_valid", out_valid, 0);
      chk("idle_we", wb_we, 0);

      // stall: only A fits in the single slot
      out_ready = 1'b0;
      beat(32'hA, 32'h0, 5'd1, 2'b10);
      #1;
      chk("stall_ready_empty", in_ready, 1);
      step();
      chk("stall_A_valid", out_valid, 1);
      chk("stall_A_data", wb_data, 32'hA);
      chk("stall_full_ready", in_ready, 0);
      beat(32'hB, 32'h0, 5'd2, 2'b10);
      step();
      chk("stall_B_held_A", wb_data, 32'hA);
      chk("stall_B_rd", wb_rd, 1);
      beat(32'hC, 32'h0, 5'd3, 2'b10);
      step();
      chk("stall_C_held_A", wb_data, 32'hA);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("release_ready", in_ready, 1);
      step();
      chk("release_empty", out_valid, 0);

      // flush with a beat held while D is offered
      out_ready = 1'b0;
      beat(32'hE, 32'h0, 5'd6, 2'b10);
      step();
      chk("flush_pre_valid", out_valid, 1);
      flush = 1'b1;
      beat(32'hD, 32'h0, 5'd7, 2'b10);
      #1;
      chk("flush_in_ready", in_ready, 1);
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("flush_valid", out_valid, 0);
      chk("flush_we", wb_we, 0);
      step();
      chk("flush_no_D", out_valid, 0);

      // reset while stalled and full
      out_ready = 1'b0;
      beat(32'hF, 32'hF0, 5'd9, 2'b11);
      step();
      chk("rst2_pre_valid", out_valid, 1);
      reset = 1'b1;
      beat(32'h77, 32'h0, 5'd8, 2'b10);
      step();
      chk("rst2_valid", out_valid, 0);
      chk("rst2_we", wb_we, 0);
      chk("rst2_rd", wb_rd, 0);
      chk("rst2_data", wb_data, 0);
      chk("rst2_in_ready", in_ready, 0);
      reset = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("rst2_after_ready", in_ready, 1);
      step();
      chk("rst2_no_stale", out_valid, 0);
      chk("rst2_no_stale_we", wb_we, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
